prio_encoder_rr8: RTL and testbench
===================================

Name: prio_encoder_rr8

Overview:
- 8-input request encoder; the inverse of the team's 3-to-8 enable decoder.
- Accepts an 8-bit request vector `d` using the same bit convention as the decoder, where code c maps to bit `d[7-c]`. Emits one 3-bit code `sel` per granted request.
- Requests are held in a pending register. A round-robin or fixed-priority scan picks the next one, and each code is presented on a valid/ready output handshake.
- Sits between request sources and the decoder, or any other `sel` consumer. Reports overrun, i.e. a request arriving for a code still pending.

Parameters:
- RR, 1, arbitration mode: 1 = round-robin over codes, 0 = fixed priority (code 0 highest, code 7 lowest).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  request strobe; `d` is sampled on edges where en=1.
- d  input  8  request vector; `d[i]` requests code 7-i.
- rdy  input  1  consumer ready; ignored while vld=0.
- clr  input  1  synchronous clear of `err`.
- sel  output  3  granted code, registered.
- vld  output  1  `sel` valid, registered.
- err  output  1  sticky overrun flag, registered.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-transfer):
  - pend=8'h00, sel=3'd0, vld=0, err=0, ptr=3'd7 (bit index).
  - Any in-flight code is dropped.
- Internal state:
  - pend[7:0]: pending requests.
  - ptr[2:0]: bit index where the scan starts.
  - Output register (sel, vld).
  - Output FSM with two states, IDLE (vld=0) and OUT (vld=1).
- Load condition: `load = !vld | rdy`.
- Scan, evaluated on the registered pend only, never the incoming d:
  - Starting at bit ptr, test bits ptr, ptr-1, ..., 0, 7, ... (descending, wrapping 0 -> 7). The first set bit is index g.
  - In code terms this is ascending order, wrapping 7 -> 0.
  - With RR=0 the scan always starts at bit 7.
- On an edge with load=1:
  - If pend != 0: sel <= ~g (equal to 7-g), vld <= 1, g is cleared from pend. If RR=1, ptr <= g-1 mod 8 (g=0 -> 7). Next state OUT.
  - If pend == 0: vld <= 0, sel holds its last value, next state IDLE.
- On an edge with vld=1 and rdy=0: sel, vld and ptr hold; state stays OUT.
- Pend update each edge:
  - `pend <= (pend & ~grant_mask) | (en ? d : 8'h00)`.
  - grant_mask is the one-hot of g when a grant loads, else 0.
  - A new request for the bit granted on the same edge re-sets that bit. This is not an overrun and the request is not lost.
- Overrun:
  - `err` is set on an edge where, for some i, en & d[i] & pend[i] is true and bit i is not being granted on that edge.
  - The duplicate request merges into the existing pend bit and is not counted twice.
- err clear:
  - clr=1 clears err on the next edge.
  - If clr and a new overrun occur on the same edge, err=1 (set wins).
- Latency:
  - A request sampled on edge E1 is in pend after E1.
  - With an empty output register or rdy=1, it appears as vld=1/sel after E2 (2 edges).
  - Peak throughput is 1 code per cycle with rdy held high.
- Width: sel is exactly the bitwise inverse of the 3-bit grant index; no arithmetic beyond the mod-8 pointer decrement.
- en=1 with d=8'h00 is legal and has no effect.

Test Plan:
- Reset and mid-transfer reset:
  - After release: sel=0, vld=0, err=0.
  - Load d=8'hFF, then pulse rst_n low mid-sequence: vld=0 immediately (asynchronous), pend cleared, no further grants.
- Single request:
  - en=1, d=8'b0000_0100 for one cycle, rdy=1: vld=1 with sel=3'd5 after the 2nd edge; vld=0 after the 3rd edge.
- Round-robin burst:
  - RR=1, en=1, d=8'hFF for one cycle, rdy=1: sel = 0,1,2,3,4,5,6,7 on 8 consecutive cycles, then vld=0.
  - A second d=8'h81 burst then yields sel 0 then 7 (after the pointer wraps).
- Backpressure and merge:
  - Codes 2 and 5 pending, rdy=0: sel=2, vld=1 held stable for 5 cycles.
  - en=1 with d=8'h20 (code 2) on the edge the grant of code 2 occurs (rdy=1): err stays 0, code 2 is re-granted later.
- Overrun and clear:
  - rdy=0 with sel=0 displayed and code 7 pending; en=1, d=8'h01: err=1 next edge.
  - clr=1: err=0.
  - clr=1 simultaneous with another overrun: err stays 1.
- Fixed priority:
  - RR=0, codes 6 and 3 pending, rdy=1: sel=3 first.
  - If code 1 arrives before the next load: sel=1, then 6.

Source files
------------

// File: rtl/prio_encoder_rr8.sv
// Pending-request encoder: 8-bit request vector to 3-bit codes, round-robin or fixed priority; 2 edges from request to vld.
// Output holds sel/vld while rdy=0; new requests keep merging into pend, and a duplicate of a pending, ungranted bit raises err.
module prio_encoder_rr8 #(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] d,
  input  logic       rdy,
  input  logic       clr,
  output logic [2:0] sel,
  output logic       vld,
  output logic       err
);

  typedef enum logic {IDLE, OUT} state_t;

  state_t     state;
  logic [7:0] pend;
  logic [2:0] ptr;
  logic [2:0] start;
  logic [2:0] idx;
  logic [2:0] g;
  logic       found;
  logic       load;
  logic       grant;
  logic [7:0] grant_mask;
  logic [7:0] req;
  logic       overrun;

  // Descending bit scan from start, wrapping 0 -> 7; bit i carries code 7-i.
  always_comb begin
    start = RR ? ptr : 3'd7;
    idx   = 3'd0;
    g     = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start - 3'(k);
      if (!found && pend[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
  end

  assign vld        = (state == OUT);
  assign load       = !vld || rdy;
  assign grant      = load && found;
  assign grant_mask = grant ? (8'(1) << g) : 8'h00;
  assign req        = en ? d : 8'h00;
  // A re-request of the bit granted on this edge is a legitimate new request, not an overrun.
  assign overrun    = |(req & pend & ~grant_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= 8'h00;
      sel   <= 3'd0;
      ptr   <= 3'd7;
      err   <= 1'b0;
    end else begin
      pend <= (pend & ~grant_mask) | req;

      if (overrun) begin
        err <= 1'b1;
      end else if (clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE, OUT: begin
          if (load) begin
            if (found) begin
              sel   <= ~g;
              state <= OUT;
              if (RR) begin
                ptr <= g - 3'd1;
              end
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr8.sv
// Scoreboard bench: stimulus queues expected codes and status checks, a negedge monitor compares.
// One instance runs round-robin, the other fixed priority, each with its own inputs.
module tb_prio_encoder_rr8;

  localparam int K_VLD   = 0;
  localparam int K_ERR   = 1;
  localparam int K_SEL   = 2;
  localparam int K_EMPTY = 3;

  typedef struct {
    int inst;
    int kind;
    int exp;
  } stat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_r, rdy_r, clr_r, vld_r, err_r;
  logic [7:0] d_r;
  logic [2:0] sel_r;
  logic       en_f, rdy_f, clr_f, vld_f, err_f;
  logic [7:0] d_f;
  logic [2:0] sel_f;

  stat_t stat_q[$];
  int    qr[$];
  int    qf[$];
  int    n_pass  = 0;
  int    n_total = 0;

  always #5 clk = ~clk;

  prio_encoder_rr8 #(.RR(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .en(en_r), .d(d_r), .rdy(rdy_r), .clr(clr_r),
    .sel(sel_r), .vld(vld_r), .err(err_r)
  );

  prio_encoder_rr8 #(.RR(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .en(en_f), .d(d_f), .rdy(rdy_f), .clr(clr_f),
    .sel(sel_f), .vld(vld_f), .err(err_f)
  );

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  task automatic expect_stat(input int inst, input int kind, input int exp);
    stat_t s;
    s.inst = inst;
    s.kind = kind;
    s.exp  = exp;
    stat_q.push_back(s);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic string pfx(input int inst);
    return (inst != 0) ? "fp" : "rr";
  endfunction

  // Monitor: handshakes pop the code queues, then any queued status checks are compared.
  always @(negedge clk) begin
    stat_t s;
    if (vld_r && rdy_r) begin
      if (qr.size() == 0) chk("rr_unexpected_grant", int'(sel_r), -1);
      else chk("rr_sel", int'(sel_r), qr.pop_front());
    end
    if (vld_f && rdy_f) begin
      if (qf.size() == 0) chk("fp_unexpected_grant", int'(sel_f), -1);
      else chk("fp_sel", int'(sel_f), qf.pop_front());
    end
    while (stat_q.size() != 0) begin
      s = stat_q.pop_front();
      case (s.kind)
        K_VLD:   chk({pfx(s.inst), "_vld"}, (s.inst != 0) ? int'(vld_f) : int'(vld_r), s.exp);
        K_ERR:   chk({pfx(s.inst), "_err"}, (s.inst != 0) ? int'(err_f) : int'(err_r), s.exp);
        K_SEL:   chk({pfx(s.inst), "_sel_held"}, (s.inst != 0) ? int'(sel_f) : int'(sel_r), s.exp);
        default: chk({pfx(s.inst), "_codes_left"}, (s.inst != 0) ? qf.size() : qr.size(), s.exp);
      endcase
    end
  end

  initial begin
    rst_n = 1'b0;
    en_r = 1'b0; d_r = 8'h00; rdy_r = 1'b0; clr_r = 1'b0;
    en_f = 1'b0; d_f = 8'h00; rdy_f = 1'b0; clr_f = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_stat(i, K_VLD, 0);
      expect_stat(i, K_ERR, 0);
      expect_stat(i, K_SEL, 0);
    end

    // Round-robin burst of all eight codes
    rdy_r = 1'b1; en_r = 1'b1; d_r = 8'hFF;
    for (int c = 0; c < 8; c++) qr.push_back(c);
    step();
    en_r = 1'b0; d_r = 8'h00;
    repeat (9) step();
    expect_stat(0, K_VLD, 0);

    // Codes 0 and 7 after the pointer has wrapped
    en_r = 1'b1; d_r = 8'h81;
    qr.push_back(0); qr.push_back(7);
    step();
    en_r = 1'b0; d_r = 8'h00;
    repeat (3) step();
    expect_stat(0, K_VLD, 0);

    // Strobe with an empty vector does nothing
    en_r = 1'b1; d_r = 8'h00;
    step();
    en_r = 1'b0;
    step();
    expect_stat(0, K_VLD, 0);
    expect_stat(0, K_ERR, 0);

    // Single request, code 5
    en_r = 1'b1; d_r = 8'h04; qr.push_back(5);
    step();
    en_r = 1'b0; d_r = 8'h00;
    step();
    expect_stat(0, K_VLD, 1);
    expect_stat(0, K_SEL, 5);
    step();
    expect_stat(0, K_VLD, 0);

    // Codes 2 and 5 under backpressure; code 2 re-requested on its own grant edge
    rdy_r = 1'b0; en_r = 1'b1; d_r = 8'h24;
    step();
    d_r = 8'h20;
    step();
    en_r = 1'b0; d_r = 8'h00;
    for (int i = 0; i < 5; i++) begin
      expect_stat(0, K_SEL, 2);
      expect_stat(0, K_VLD, 1);
      step();
    end
    expect_stat(0, K_ERR, 0);
    rdy_r = 1'b1;
    qr.push_back(2); qr.push_back(5); qr.push_back(2);
    repeat (5) step();
    expect_stat(0, K_VLD, 0);
    expect_stat(0, K_ERR, 0);

    // Overrun on pending code 7 while code 0 is stalled, then clear
    rdy_r = 1'b0; en_r = 1'b1; d_r = 8'h80; qr.push_back(0);
    step();
    d_r = 8'h01; qr.push_back(7);
    step();
    expect_stat(0, K_SEL, 0);
    expect_stat(0, K_VLD, 1);
    expect_stat(0, K_ERR, 0);
    step();
    expect_stat(0, K_ERR, 1);
    clr_r = 1'b1;
    step();
    expect_stat(0, K_ERR, 1);
    en_r = 1'b0; d_r = 8'h00;
    step();
    expect_stat(0, K_ERR, 0);
    clr_r = 1'b0; rdy_r = 1'b1;
    repeat (4) step();
    expect_stat(0, K_VLD, 0);

    // Asynchronous reset in the middle of a burst
    en_r = 1'b1; d_r = 8'hFF;
    for (int c = 0; c < 8; c++) qr.push_back(c);
    step();
    en_r = 1'b0; d_r = 8'h00;
    repeat (3) step();
    rst_n = 1'b0;
    qr.delete();
    expect_stat(0, K_VLD, 0);
    expect_stat(0, K_SEL, 0);
    expect_stat(0, K_ERR, 0);
    step();
    rst_n = 1'b1;
    repeat (10) step();
    expect_stat(0, K_VLD, 0);
    expect_stat(0, K_EMPTY, 0);

    // Fixed priority: codes 6 and 3, then code 1 arrives before the next load
    rdy_f = 1'b1; en_f = 1'b1; d_f = 8'h12; qf.push_back(3);
    step();
    d_f = 8'h40; qf.push_back(1); qf.push_back(6);
    step();
    en_f = 1'b0; d_f = 8'h00;
    expect_stat(1, K_SEL, 3);
    expect_stat(1, K_VLD, 1);
    step();
    expect_stat(1, K_SEL, 1);
    step();
    expect_stat(1, K_SEL, 6);
    step();
    expect_stat(1, K_VLD, 0);
    expect_stat(1, K_ERR, 0);
    expect_stat(1, K_EMPTY, 0);

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
